// File: rtl/imem_loadable.sv
// imem_loadable: synchronous-read instruction memory with a runtime image loader.
//
// A program image is streamed in through the load port while the block is in
// LOAD. The fetch port is only served in RUN. Each fetch is read in the accept
// cycle and answered exactly LATENCY cycles later. Responses arrive in order,
// and the port accepts one request per cycle.
//
// Parameters
//   ADDR_BITS  word-address width; depth = 2**ADDR_BITS words
//   LATENCY    fetch read latency in cycles (1..3)
//   DATA_W     instruction word width
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   load_start          begin a new image load (pointer back to word 0)
//   load_valid          load_data holds a word to store
//   load_data           instruction word to store
//   load_last           final word of the image (qualifies load_valid)
//   fetch_req           fetch request
//   fetch_addr          byte address
//   fetch_ready         request accepted this cycle (state RUN)
//   fetch_rvalid        fetch response valid
//   fetch_rdata         instruction word, forced to 0 on error
//   fetch_err           {out_of_range, misaligned}, valid with fetch_rvalid
//   loaded              state is RUN
//   load_ovf            sticky: image ran past the last word
//   load_sum            mod-2^32 sum of the words written in this load
//
// Optional feature
//   IMEM_LOAD_CHECKSUM_EN  when defined, load_sum accumulates written words;
//                          otherwise load_sum is tied to 0.

module imem_loadable #(
    parameter int ADDR_BITS = 9,
    parameter int LATENCY   = 1,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_ready,
    output logic              fetch_rvalid,
    output logic [DATA_W-1:0] fetch_rdata,
    output logic [1:0]        fetch_err,
    output logic              loaded,
    output logic              load_ovf,
    output logic [31:0]       load_sum
);

    localparam int                   DEPTH    = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] PTR_LAST = '1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t               state;
    logic [ADDR_BITS-1:0] load_ptr;
    logic [DATA_W-1:0]    mem [DEPTH];

    logic                 load_we;
    logic                 accept;
    logic                 misaligned;
    logic                 out_of_range;
    logic [ADDR_BITS-1:0] fetch_idx;

    // load_start outranks load_valid, so a restart never stores a word.
    assign load_we      = (state == LOAD) && load_valid && !load_start;
    assign accept       = fetch_req && (state == RUN);
    assign misaligned   = |fetch_addr[1:0];
    assign out_of_range = |fetch_addr[31:ADDR_BITS+2];
    assign fetch_idx    = fetch_addr[ADDR_BITS+1:2];

    assign fetch_ready  = (state == RUN);
    assign loaded       = (state == RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            load_ptr <= '0;
            load_ovf <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state    <= LOAD;
                        load_ptr <= '0;
                    end
                end
                LOAD: begin
                    if (load_start) begin
                        load_ptr <= '0;
                    end else if (load_valid) begin
                        if (load_last) begin
                            state <= RUN;
                        end else if (load_ptr == PTR_LAST) begin
                            // Last slot filled with more image to come: stop
                            // here rather than wrap onto word 0.
                            state    <= RUN;
                            load_ovf <= 1'b1;
                        end else begin
                            load_ptr <= load_ptr + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (load_start) begin
                        state    <= LOAD;
                        load_ptr <= '0;
                        load_ovf <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory array is not reset, so contents survive a reset. A load word
    // presented in the reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (!reset && load_we) begin
            mem[load_ptr] <= load_data;
        end
    end

    logic              vld_p  [LATENCY];
    logic [DATA_W-1:0] data_p [LATENCY];
    logic [1:0]        err_p  [LATENCY];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                vld_p[i]  <= 1'b0;
                data_p[i] <= '0;
                err_p[i]  <= 2'b00;
            end
        end else begin
            // stage 0: array read in the accept cycle (old word if written now)
            vld_p[0]  <= accept;
            data_p[0] <= (accept && !misaligned && !out_of_range) ? mem[fetch_idx] : '0;
            err_p[0]  <= accept ? {out_of_range, misaligned} : 2'b00;
            // stages 1..LATENCY-1: plain delay line
            for (int i = 1; i < LATENCY; i++) begin
                vld_p[i]  <= vld_p[i-1];
                data_p[i] <= data_p[i-1];
                err_p[i]  <= err_p[i-1];
            end
        end
    end

    assign fetch_rvalid = vld_p[LATENCY-1];
    assign fetch_rdata  = data_p[LATENCY-1];
    assign fetch_err    = err_p[LATENCY-1];

`ifdef IMEM_LOAD_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset || load_start) begin
            load_sum <= '0;
        end else if (load_we) begin
            load_sum <= load_sum + 32'(load_data);
        end
    end
`else
    assign load_sum = '0;
`endif

endmodule

// File: tb/tb_imem_loadable.sv
// Testbench for imem_loadable. Two instances share one stimulus stream:
//   dut_big   ADDR_BITS=9, LATENCY=1
//   dut_small ADDR_BITS=2, LATENCY=3
// A behavioural model keeps, per instance, a word array, the load state and
// a queue of pending responses stamped with their due cycle.

module tb_imem_loadable;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, load_start, load_valid, load_last, fetch_req;
    logic [31:0] load_data, fetch_addr;

    logic        ready  [2];
    logic        rvalid [2];
    logic [31:0] rdata  [2];
    logic [1:0]  err    [2];
    logic        loaded [2];
    logic        ovf    [2];
    logic [31:0] lsum   [2];

    imem_loadable #(.ADDR_BITS(9), .LATENCY(1), .DATA_W(32)) dut_big (
        .clk(clk), .reset(reset),
        .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ready(ready[0]), .fetch_rvalid(rvalid[0]),
        .fetch_rdata(rdata[0]), .fetch_err(err[0]),
        .loaded(loaded[0]), .load_ovf(ovf[0]), .load_sum(lsum[0])
    );

    imem_loadable #(.ADDR_BITS(2), .LATENCY(3), .DATA_W(32)) dut_small (
        .clk(clk), .reset(reset),
        .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ready(ready[1]), .fetch_rvalid(rvalid[1]),
        .fetch_rdata(rdata[1]), .fetch_err(err[1]),
        .loaded(loaded[1]), .load_ovf(ovf[1]), .load_sum(lsum[1])
    );

    localparam int S_IDLE = 0;
    localparam int S_LOAD = 1;
    localparam int S_RUN  = 2;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic [1:0]  err;
    } resp_t;

    resp_t       rq   [2][$];
    logic [31:0] mref [2][512];
    int          mst  [2];
    int unsigned mptr [2];
    bit          movf [2];
    logic [31:0] msum [2];

    int cyc;
    int vectors;
    int miscompares;

    function automatic int abits(int k);
        return (k == 0) ? 9 : 2;
    endfunction

    function automatic int lat(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        int unsigned depth;
        int unsigned idx;
        bit          mis;
        bit          oor;
        resp_t       r;
        for (int k = 0; k < 2; k++) begin
            depth = 32'd1 << abits(k);
            if (reset) begin
                mst[k]  = S_IDLE;
                mptr[k] = 0;
                movf[k] = 1'b0;
                msum[k] = 32'd0;
                rq[k].delete();
            end else begin
                // fetch sees the array contents from before this cycle's write
                if (fetch_req && mst[k] == S_RUN) begin
                    mis    = (fetch_addr % 4) != 0;
                    oor    = (fetch_addr >> (abits(k) + 2)) != 0;
                    idx    = (fetch_addr / 4) % depth;
                    r.due  = cyc + lat(k);
                    r.err  = {oor, mis};
                    r.data = (mis || oor) ? 32'd0 : mref[k][idx];
                    rq[k].push_back(r);
                end
                if (load_start) begin
                    if (mst[k] == S_RUN) movf[k] = 1'b0;
                    mst[k]  = S_LOAD;
                    mptr[k] = 0;
                    msum[k] = 32'd0;
                end else if (mst[k] == S_LOAD && load_valid) begin
                    mref[k][mptr[k]] = load_data;
                    msum[k] = msum[k] + load_data;
                    if (load_last) begin
                        mst[k] = S_RUN;
                    end else if (mptr[k] == depth - 1) begin
                        mst[k]  = S_RUN;
                        movf[k] = 1'b1;
                    end else begin
                        mptr[k] = mptr[k] + 1;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        bit    exp_rv;
        resp_t r;
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("ready%0d", k),  32'(ready[k]),  32'(mst[k] == S_RUN));
            chk($sformatf("loaded%0d", k), 32'(loaded[k]), 32'(mst[k] == S_RUN));
            chk($sformatf("ovf%0d", k),    32'(ovf[k]),    32'(movf[k]));
`ifdef IMEM_LOAD_CHECKSUM_EN
            chk($sformatf("sum%0d", k),    lsum[k],        msum[k]);
`else
            chk($sformatf("sum%0d", k),    lsum[k],        32'd0);
`endif
            exp_rv = (rq[k].size() > 0) && (rq[k][0].due == cyc);
            chk($sformatf("rvalid%0d", k), 32'(rvalid[k]), 32'(exp_rv));
            if (exp_rv) begin
                r = rq[k].pop_front();
                chk($sformatf("rdata%0d", k), rdata[k],      r.data);
                chk($sformatf("err%0d", k),   32'(err[k]),   32'(r.err));
            end
        end
    endtask

    task automatic quiet();
        load_start = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_data  = 32'd0;
        fetch_req  = 1'b0;
        fetch_addr = 32'd0;
    endtask

    task automatic load_word(logic [31:0] d, bit last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic fetch(logic [31:0] a);
        fetch_req  = 1'b1;
        fetch_addr = a;
        tick();
        fetch_req  = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        quiet();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        // Fetch before any load: never accepted, never answered.
        fetch_req = 1'b1;
        repeat (5) tick();
        fetch_req = 1'b0;

        // Unterminated image of 513 words starting 1..5: small instance keeps
        // 1..4 and overflows, big instance overflows on word 512.
        load_start = 1'b1; tick(); load_start = 1'b0;
        for (int i = 0; i < 513; i++) load_word((i < 5) ? 32'(i + 1) : $urandom, 1'b0);
        fetch(32'h0);
        repeat (4) tick();

        // Basic three-word program, then back-to-back fetches and errors.
        load_start = 1'b1; tick(); load_start = 1'b0;
        load_word(32'hE3A09000, 1'b0);
        load_word(32'hE3A00008, 1'b0);
        load_word(32'hEB00000A, 1'b1);
        tick();
        fetch(32'h0); fetch(32'h4); fetch(32'h8); fetch(32'hC);
        fetch(32'h6); fetch(32'h800);
        repeat (4) tick();

        // Reload while responses are still in flight.
        fetch(32'h0);
        fetch_req = 1'b1; fetch_addr = 32'h4; load_start = 1'b1;
        tick();
        quiet();
        load_word(32'hAAAA0000, 1'b0);
        load_word(32'hBBBB0001, 1'b1);
        repeat (4) tick();

        // Reset mid-load; the word offered during reset is not stored.
        load_start = 1'b1; tick(); load_start = 1'b0;
        load_word(32'h11110000, 1'b0);
        load_word(32'h22220001, 1'b0);
        reset = 1'b1; load_valid = 1'b1; load_data = 32'h33330002;
        tick();
        reset = 1'b0; quiet();
        load_start = 1'b1; tick(); load_start = 1'b0;
        load_word(32'h44440000, 1'b0);
        load_word(32'h55550001, 1'b0);
        load_word(32'h66660002, 1'b1);
        for (int i = 0; i < 4; i++) fetch(32'(i * 4));
        repeat (4) tick();

        // Checksum wrap: FFFFFFFF + 2.
        load_start = 1'b1; tick(); load_start = 1'b0;
        load_word(32'hFFFFFFFF, 1'b0);
        load_word(32'h00000002, 1'b1);
        tick();

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            reset      = ($urandom_range(0, 299) == 0);
            load_start = ($urandom_range(0, 49) == 0);
            load_valid = ($urandom_range(0, 1) == 1);
            load_last  = ($urandom_range(0, 9) == 0);
            load_data  = $urandom;
            fetch_req  = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 1) == 1)
                fetch_addr = 32'($urandom_range(0, 3)) << 2;
            else
                fetch_addr = 32'($urandom_range(0, 511)) << 2;
            if ($urandom_range(0, 9) == 0) fetch_addr[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 19) == 0) fetch_addr[31:11] = 21'($urandom);
            tick();
        end
        quiet();
        reset = 1'b0;
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
- Parametrised, synchronous-read instruction memory for the ARM core and its test harness.
- Replaces fixed hard-coded ROM images with a runtime loader port, so the bench streams a program image in before releasing the core.
- Fetch side is pipelined, has configurable read latency, and flags misaligned and out-of-range accesses.

Parameters:
ADDR_BITS, 9, word-address width; depth = 2**ADDR_BITS words (default 512)
LATENCY, 1, fetch read latency in cycles; legal values 1..3
DATA_W, 32, instruction word width

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
load_start  in  1  begin a new image load; pointer returns to word 0
load_valid  in  1  load_data is valid this cycle
load_data  in  DATA_W  instruction word to store
load_last  in  1  qualifies load_valid; this is the final image word
fetch_req  in  1  fetch request
fetch_addr  in  32  byte address
fetch_ready  out  1  request accepted this cycle (state RUN)
fetch_rvalid  out  1  fetch response valid
fetch_rdata  out  DATA_W  instruction word; 0 on error
fetch_err  out  2  bit0 misaligned, bit1 out of range; valid with rvalid
loaded  out  1  state is RUN
load_ovf  out  1  sticky: image exceeded depth
load_sum  out  32  load checksum (optional feature)

Behaviour:
- FSM states: IDLE, LOAD, RUN. Reset value is IDLE.
- Reset values: fetch_rvalid=0, fetch_rdata=0, fetch_err=0, loaded=0, load_ovf=0, load_sum=0, load pointer=0. All pipeline valid bits clear.
- Memory contents are not reset and are retained across reset.
- IDLE: load_start -> LOAD with pointer=0. load_valid is ignored.
- LOAD: each load_valid writes mem[ptr]=load_data, then ptr+1.
  - load_valid with load_last -> RUN after the write.
  - Write at ptr=DEPTH-1 without load_last: the word is written, load_ovf is set, state -> RUN, and further load words are ignored.
  - load_start during LOAD: ptr=0 and the load restarts. load_start has priority over load_valid in the same cycle.
- RUN: load_start -> LOAD, ptr=0, load_ovf cleared.
- fetch_ready = (state==RUN). Requests outside RUN are dropped: no response, no error.
- Accepted fetch (fetch_req & fetch_ready):
  - Word index = fetch_addr[ADDR_BITS+1:2].
  - Misaligned if fetch_addr[1:0]!=0.
  - Out of range if fetch_addr[31:ADDR_BITS+2]!=0.
  - Memory is read in the accept cycle.
  - fetch_rvalid asserts exactly LATENCY cycles after accept, with rdata and err. On any error, rdata=0.
- Throughput: one request per cycle, responses in order, no bubbles.
- Transition RUN->LOAD with fetches in flight: responses still complete with data read at accept time. A load write in the same cycle as an accepted read returns the old word (read-before-write).
- Reset mid-operation:
  - Pipeline flushed immediately (no rvalid the next cycle), state IDLE.
  - Memory writes completed before reset are kept.
  - A load_valid in the reset cycle is not written.
- load_ptr is ADDR_BITS wide and never wraps; overflow terminates the load as above.

Optional Feature:
- Macro: IMEM_LOAD_CHECKSUM_EN.
- Defined:
  - load_sum holds the mod-2^32 sum of every word actually written in the current load.
  - Cleared on reset and on load_start. Held in RUN.
  - Ignored words (post-overflow, IDLE) are not summed.
- Undefined: load_sum is tied to 0 and no adder is instantiated.

Test Plan:
- Basic load and fetch:
  - After reset, load_start, then load E3A09000, E3A00008, EB00000A (last) -> loaded=1 one cycle after the last word.
  - Fetches of 0x0, 0x4, 0x8 on consecutive cycles, LATENCY=1 -> rvalid on the next three cycles with those words in order, err=0.
- Fetch before load: fetch_req with reset just released -> fetch_ready=0, no rvalid for 5 cycles.
- Error responses after loading:
  - fetch 0x6 -> rdata=0, err=01.
  - fetch 0x800 with ADDR_BITS=9 -> rdata=0, err=10.
- Overflow with ADDR_BITS=2: load 5 words 1..5 with no load_last -> words 1..4 stored, load_ovf=1, RUN entered; fetch 0x0 returns 1.
- LATENCY=3 and reload:
  - Back-to-back fetches of 0x0..0xC -> first rvalid 3 cycles after the first accept, then 4 consecutive rvalids.
  - load_start asserted while 2 responses are in flight -> both responses still delivered with the old data.
- Reset mid-load and checksum:
  - Reset after 2 of 4 words -> state IDLE; a new load of 3 words ends with loaded=1.
  - With IMEM_LOAD_CHECKSUM_EN, load 0xFFFFFFFF, 0x00000002 -> load_sum=0x00000001.
